// File: rtl/mole_scheduler.sv
// Round sequencer for whack-a-mole: alternates mole-down gaps with mole-up windows of LFSR-picked holes.
// Optional MOLE_SPEEDUP_EN shortens the up window after each full clear.
module mole_scheduler #(
    parameter int          NUM_HOLES       = 18,
    parameter int          MOLES_PER_ROUND = 3,
    parameter int          DOWN_CYCLES     = 12_500_000,
    parameter int          UP_CYCLES       = 25_000_000,
    parameter int          MIN_UP_CYCLES   = 5_000_000,
    parameter int          STEP_CYCLES     = 2_500_000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 game_in_progress,
    input  logic                 full_clear_hit,
    output logic [NUM_HOLES-1:0] mole_positions,
    output logic                 round_missed,
    output logic [7:0]           rounds_cleared,
    output logic [1:0]           state_dbg
);
    localparam int TMAX = (DOWN_CYCLES > UP_CYCLES) ? DOWN_CYCLES : UP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = (MOLES_PER_ROUND > 1) ? $clog2(MOLES_PER_ROUND) : 1;

    localparam logic [TW-1:0] DOWN_LOAD = TW'(DOWN_CYCLES - 1);
    localparam logic [TW-1:0] UP_INIT   = TW'(UP_CYCLES);
    localparam logic [TW-1:0] MIN_UP    = TW'(MIN_UP_CYCLES);
    localparam logic [TW-1:0] STEP      = TW'(STEP_CYCLES);
    localparam logic [CW-1:0] LAST_DRAW = CW'(MOLES_PER_ROUND - 1);
    localparam logic [NUM_HOLES-1:0] ONE_HOT0 = {{(NUM_HOLES-1){1'b0}}, 1'b1};

`ifdef MOLE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DOWN, S_GEN, S_UP} state_t;

    state_t                 state;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          up_len;
    logic [CW-1:0]          draw_cnt;
    logic [NUM_HOLES-1:0]   pattern;
    logic [15:0]            lfsr;
    logic                   lfsr_fb;
    logic [NUM_HOLES-1:0]   draw_bit;
    logic [TW-1:0]          up_len_next;

    assign state_dbg = state;
    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign draw_bit  = ONE_HOT0 << (32'(lfsr[7:0]) % NUM_HOLES);

    // Shorter window after a clear, never below the floor.
    always_comb begin
        up_len_next = up_len;
        if (SPEEDUP) begin
            if (int'(up_len) >= MIN_UP_CYCLES + STEP_CYCLES)
                up_len_next = up_len - STEP;
            else
                up_len_next = MIN_UP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            mole_positions <= '0;
            round_missed   <= 1'b0;
            rounds_cleared <= 8'd0;
            timer          <= '0;
            up_len         <= UP_INIT;
            draw_cnt       <= '0;
            pattern        <= '0;
            lfsr           <= LFSR_SEED;
        end else begin
            lfsr         <= {lfsr[14:0], lfsr_fb};
            round_missed <= 1'b0;
            if (!game_in_progress) begin
                state          <= S_IDLE;
                mole_positions <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state          <= S_DOWN;
                        timer          <= DOWN_LOAD;
                        rounds_cleared <= 8'd0;
                        up_len         <= UP_INIT;
                        mole_positions <= '0;
                    end
                    S_DOWN: begin
                        mole_positions <= '0;
                        if (timer == '0) begin
                            state    <= S_GEN;
                            pattern  <= '0;
                            draw_cnt <= '0;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_GEN: begin
                        pattern <= pattern | draw_bit;
                        if (draw_cnt == LAST_DRAW) begin
                            state          <= S_UP;
                            timer          <= up_len - 1'b1;
                            mole_positions <= pattern | draw_bit;
                        end else begin
                            draw_cnt <= draw_cnt + 1'b1;
                        end
                    end
                    S_UP: begin
                        // A hit on the final cycle still wins over the timeout.
                        if (full_clear_hit) begin
                            state          <= S_DOWN;
                            timer          <= DOWN_LOAD;
                            mole_positions <= '0;
                            up_len         <= up_len_next;
                            if (rounds_cleared != 8'hFF)
                                rounds_cleared <= rounds_cleared + 8'd1;
                        end else if (timer == '0) begin
                            state          <= S_DOWN;
                            timer          <= DOWN_LOAD;
                            mole_positions <= '0;
                            round_missed   <= 1'b1;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
